fluxo_dados_genius_param: RTL
=============================

Name: fluxo_dados_genius_param

Overview:
- Parametrised next-generation datapath for the memory-sequence game.
- Sits under the game control unit: it receives control strobes and returns status flags, as the previous datapath did.
- Generalised to NB buttons/LEDs and 2^AW sequence depth.
- New over the previous generation: LFSR-based random sequence fill, a four-level round-limit selector, a registered timeout enable, one-hot validity checking of button presses, and a saturating error counter.

Parameters:
- NB, 4, number of buttons/LEDs; power of 2, range 2..8.
- AW, 4, address width; sequence depth = 2^AW.
- TIMEOUT_M, 5000, modulus of the play-timeout counter, in clocks.
- EXIB_M, 2000, modulus of the LED-display counter, in clocks.
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- zeraCL / contaCL  in  1/1  round counter clear / increment.
- zeraC / contaC  in  1/1  address counter clear / increment.
- registraModo  in  1  capture modo.
- modo  in  3  [1:0] round-limit level; [2] timeout enable.
- escreve  in  1  RAM write strobe.
- fonte  in  2  write source: 0 = botoes, 1 = fixed one-hot bit0, 2 = LFSR, 3 = reserved (writes botoes).
- zeraR / registraR  in  1/1  button register clear / load.
- botoes  in  NB  button inputs.
- zeraTimeout / contaTimeout  in  1/1  timeout counter clear / enable.
- zeraExibicao / contaExibicao  in  1/1  display counter clear / enable.
- seletorLedsBM  in  1  LED source: 0 = botoes, 1 = memory.
- mostraLeds  in  1  LED enable.
- contaErro  in  1  increment error counter.
- fimRodada  out  1  address == round.
- fimTotal  out  1  round == selected limit.
- fimC  out  1  address == 2^AW-1.
- igual  out  1  memory word == button register.
- jogada_valida  out  1  button register is exactly one-hot.
- jogada_feita  out  1  one-cycle pulse on rising edge of OR(botoes).
- fimTimeout  out  1  timeout terminal count.
- fimExibicao  out  1  display terminal count.
- leds  out  NB  LED drive.
- erros  out  4  error count.
- db_contagem  out  AW  address counter value.
- db_sequencia  out  AW  round counter value.
- db_memoria  out  NB  memory read word.
- db_jogada  out  NB  button register value.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - All counters, the button register, erros, the mode register and the edge-detector flop clear to 0.
  - LFSR loads LFSR_SEED.
  - RAM contents are not reset.
  - Post-reset outputs: leds = 0, jogada_feita = 0, fimTimeout = 0, fimExibicao = 0.
- Counter priority: in every counter, clear takes priority over count.
- Round and address counters: AW bits; increment wraps 2^AW-1 -> 0.
- Mode register: on registraModo, capture the limit from modo[1:0]:
  - 00 -> 2^AW-1
  - 01 -> 2^(AW-1)-1
  - 10 -> 2^(AW-2)-1
  - 11 -> 3
  - modo[2] is captured at the same time as the timeout enable.
- Combinational flags:
  - fimTotal = (round == limit).
  - fimRodada = (address == round).
  - fimC = (address == 2^AW-1).
- RAM: 2^AW x NB.
  - Write is synchronous at address = address counter, when escreve = 1.
  - Read is asynchronous at the same address; a write is visible on db_memoria the next cycle.
- LFSR: 16-bit, taps 16/14/13/11, advances every clock.
  - fonte = 2 writes a one-hot word with bit (lfsr mod NB) set, using the pre-advance value.
  - The written word is always one-hot.
- Button register: loads botoes on registraR.
  - igual = (mem word == reg), bitwise over NB bits.
  - jogada_valida = popcount(reg) == 1.
- Edge detector: registers OR(botoes).
  - jogada_feita = OR(botoes) & ~previous.
  - Asserted for exactly one cycle per press, including while botoes is held.
- Timeout counter:
  - Counts 0..TIMEOUT_M-1 when contaTimeout = 1 and timeout enable = 1.
  - Wraps to 0 after TIMEOUT_M-1.
  - fimTimeout = (count == TIMEOUT_M-1) & enable.
  - With enable = 0 the count holds and fimTimeout = 0.
- Display counter: same behaviour with EXIB_M; it is never gated by the timeout enable.
- leds = mostraLeds ? (seletorLedsBM ? memword : botoes) : 0, combinational.
- erros: increments on contaErro and saturates at 15; it is cleared only by reset.
- Simultaneous events:
  - escreve together with contaC writes the old address, then increments.
  - registraModo mid-round takes effect on fimTotal the next cycle.

Test Plan:
- Reset, then registraModo with modo = 3'b111; pulse contaCL 3 times -> fimTotal = 1 after the third pulse; with AW = 4, a level-01 configuration asserts fimTotal at round 7.
- fonte = 2 and escreve over 16 consecutive addresses -> every db_memoria readback has exactly one bit set; the sequence after reset is repeatable.
- Write 4'b0100 at address 0; load the register with 0100 -> igual = 1 and jogada_valida = 1; load 0110 -> igual = 0 and jogada_valida = 0.
- Hold botoes = 0001 for 10 cycles -> jogada_feita is high for exactly 1 cycle.
- With modo[2] = 1, contaTimeout held for 5000 cycles -> fimTimeout high on cycle 5000; with modo[2] = 0 -> fimTimeout never asserts.
- Pulse contaErro 20 times -> erros = 15; assert reset_n = 0 mid-count -> all counters read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fluxo_dados_genius_param.sv
// Datapath for the memory-sequence game, parametrised on button count (NB) and
// sequence depth (2^AW). Receives level strobes from the control unit and
// returns status flags.
// Strobe semantics: every zera*/conta*/registra*/escreve input is sampled on
// the rising clock edge and acts for exactly that edge; there is no
// back-pressure, so a strobe held for N cycles acts N times.
module fluxo_dados_genius_param #(
  parameter int          NB        = 4,
  parameter int          AW        = 4,
  parameter int          TIMEOUT_M = 5000,
  parameter int          EXIB_M    = 2000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          zeraCL,
  input  logic          contaCL,
  input  logic          zeraC,
  input  logic          contaC,
  input  logic          registraModo,
  input  logic [2:0]    modo,
  input  logic          escreve,
  input  logic [1:0]    fonte,
  input  logic          zeraR,
  input  logic          registraR,
  input  logic [NB-1:0] botoes,
  input  logic          zeraTimeout,
  input  logic          contaTimeout,
  input  logic          zeraExibicao,
  input  logic          contaExibicao,
  input  logic          seletorLedsBM,
  input  logic          mostraLeds,
  input  logic          contaErro,
  output logic          fimRodada,
  output logic          fimTotal,
  output logic          fimC,
  output logic          igual,
  output logic          jogada_valida,
  output logic          jogada_feita,
  output logic          fimTimeout,
  output logic          fimExibicao,
  output logic [NB-1:0] leds,
  output logic [3:0]    erros,
  output logic [AW-1:0] db_contagem,
  output logic [AW-1:0] db_sequencia,
  output logic [NB-1:0] db_memoria,
  output logic [NB-1:0] db_jogada
);

  localparam int DEPTH = 1 << AW;
  localparam int LB    = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW    = (TIMEOUT_M > 1) ? $clog2(TIMEOUT_M) : 1;
  localparam int EW    = (EXIB_M > 1) ? $clog2(EXIB_M) : 1;

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_M - 1);
  localparam logic [EW-1:0] EXIB_LAST    = EW'(EXIB_M - 1);
  localparam logic [AW-1:0] ADDR_LAST    = AW'(DEPTH - 1);

  logic [AW-1:0] roundCnt;
  logic [AW-1:0] addrCnt;
  logic [AW-1:0] limitReg;
  logic [AW-1:0] limitSel;
  logic          timeoutEn;
  logic [NB-1:0] mem [DEPTH];
  logic [NB-1:0] memWord;
  logic [NB-1:0] wrData;
  logic [15:0]   lfsr;
  logic          lfsrFeedback;
  logic [NB-1:0] regJogada;
  logic [LB:0]   onesCount;
  logic          anyBotao;
  logic          prevAny;
  logic [TW-1:0] timeoutCnt;
  logic [EW-1:0] exibCnt;
  logic [3:0]    errCnt;

  // Round counter: clear wins over increment, wraps at 2^AW.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     roundCnt <= '0;
    else if (zeraCL)  roundCnt <= '0;
    else if (contaCL) roundCnt <= roundCnt + 1'b1;
  end

  // Address counter: clear wins over increment, wraps at 2^AW.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    addrCnt <= '0;
    else if (zeraC)  addrCnt <= '0;
    else if (contaC) addrCnt <= addrCnt + 1'b1;
  end

  // Decode the requested round-limit level into a last-round index.
  always_comb begin
    limitSel = ADDR_LAST;
    case (modo[1:0])
      2'b00:   limitSel = ADDR_LAST;
      2'b01:   limitSel = AW'((1 << (AW - 1)) - 1);
      2'b10:   limitSel = AW'((1 << (AW - 2)) - 1);
      default: limitSel = AW'(3);
    endcase
  end

  // Mode register: round limit plus the timeout enable bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      limitReg  <= '0;
      timeoutEn <= 1'b0;
    end else if (registraModo) begin
      limitReg  <= limitSel;
      timeoutEn <= modo[2];
    end
  end

  assign fimTotal  = (roundCnt == limitReg);
  assign fimRodada = (addrCnt == roundCnt);
  assign fimC      = (addrCnt == ADDR_LAST);

  // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsrFeedback = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // LFSR free-runs every clock so the fill pattern depends on timing since reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsrFeedback, lfsr[15:1]};
  end

  // Select the RAM write word; the LFSR source is forced one-hot.
  always_comb begin
    wrData = botoes;
    case (fonte)
      2'd1: wrData = NB'(1);
      2'd2: begin
        wrData = '0;
        wrData[lfsr[LB-1:0]] = 1'b1;
      end
      default: wrData = botoes;
    endcase
  end

  // Sequence RAM: synchronous write at the current address, no reset.
  always_ff @(posedge clock) begin
    if (escreve) mem[addrCnt] <= wrData;
  end

  assign memWord = mem[addrCnt];

  // Button register: clear wins over load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       regJogada <= '0;
    else if (zeraR)     regJogada <= '0;
    else if (registraR) regJogada <= botoes;
  end

  // Population count of the captured press for the one-hot check.
  always_comb begin
    onesCount = '0;
    for (int i = 0; i < NB; i++) begin
      onesCount = onesCount + {{LB{1'b0}}, regJogada[i]};
    end
  end

  assign igual         = (memWord == regJogada);
  assign jogada_valida = (onesCount == (LB + 1)'(1));

  assign anyBotao = |botoes;

  // Remember whether any button was down last cycle for press-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prevAny <= 1'b0;
    else          prevAny <= anyBotao;
  end

  assign jogada_feita = anyBotao & ~prevAny;

  // Play-timeout counter: only advances when the mode enables timeouts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        timeoutCnt <= '0;
    else if (zeraTimeout)                timeoutCnt <= '0;
    else if (contaTimeout && timeoutEn) begin
      if (timeoutCnt == TIMEOUT_LAST)    timeoutCnt <= '0;
      else                               timeoutCnt <= timeoutCnt + 1'b1;
    end
  end

  assign fimTimeout = (timeoutCnt == TIMEOUT_LAST) & timeoutEn;

  // LED display counter: same shape as the timeout, never gated.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 exibCnt <= '0;
    else if (zeraExibicao)        exibCnt <= '0;
    else if (contaExibicao) begin
      if (exibCnt == EXIB_LAST)   exibCnt <= '0;
      else                        exibCnt <= exibCnt + 1'b1;
    end
  end

  assign fimExibicao = (exibCnt == EXIB_LAST);

  // Error counter saturates at 15 and is only cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          errCnt <= '0;
    else if (contaErro && errCnt != 4'hF)  errCnt <= errCnt + 1'b1;
  end

  assign leds         = mostraLeds ? (seletorLedsBM ? memWord : botoes) : '0;
  assign erros        = errCnt;
  assign db_contagem  = addrCnt;
  assign db_sequencia = roundCnt;
  assign db_memoria   = memWord;
  assign db_jogada    = regJogada;

endmodule
